// File: rtl/program_launcher.sv
// Run controller that launches P1/P2/P3 on TopLevel through its Start/Ack handshake.
// Latency: Start/Busy rise one edge after an accepted Req; Done rises one edge after Ack (or timeout).
// Backpressure: none; Req is accepted only in IDLE and is dropped (not queued) while busy.
//
// Ports:
//   Clk, Reset      - system clock, synchronous active-high reset
//   Req, ProgSel    - launch request and program select (1..3 valid, 0 ignored)
//   Ack             - completion flag from TopLevel, honoured only in RUN
//   Start           - start pulse, high for START_LEN cycles
//   StartAddr       - start address of the accepted program, held until the next accept
//   Busy            - high while launching or running
//   Done            - single-cycle pulse at the end of every run (normal or timed out)
//   Timeout         - sticky abort flag, cleared by the next accepted request
//   CycleCount      - RUN cycles of the last run, held until the next accept
//   LastProg        - ProgSel of the last accepted request
module program_launcher #(
  parameter int PC_W           = 10,
  parameter int CNT_W          = 16,
  parameter int START_LEN      = 1,
  parameter int P1_ADDR        = 0,
  parameter int P2_ADDR        = 0,
  parameter int P3_ADDR        = 0,
  parameter int TIMEOUT_CYCLES = 2**CNT_W-1
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Req,
  input  logic [1:0]       ProgSel,
  input  logic             Ack,
  output logic             Start,
  output logic [PC_W-1:0]  StartAddr,
  output logic             Busy,
  output logic             Done,
  output logic             Timeout,
  output logic [CNT_W-1:0] CycleCount,
  output logic [1:0]       LastProg
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_RUN    = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  // Last value of the width counter before leaving LAUNCH.
  localparam logic [3:0]       W_LAST = 4'(START_LEN - 1);
  localparam logic [CNT_W-1:0] TO_LIM = CNT_W'(TIMEOUT_CYCLES);

  state_t          state;
  state_t          state_nxt;
  logic [3:0]      wcnt;
  logic            accept;
  logic            w_inc;
  logic            run_inc;
  logic            run_to;
  logic [PC_W-1:0] sel_addr;

  // Start address lookup for the program being requested.
  always_comb begin
    sel_addr = '0;
    case (ProgSel)
      2'd1:    sel_addr = PC_W'(P1_ADDR);
      2'd2:    sel_addr = PC_W'(P2_ADDR);
      2'd3:    sel_addr = PC_W'(P3_ADDR);
      default: sel_addr = '0;
    endcase
  end

  // State register.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and datapath control.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    w_inc     = 1'b0;
    run_inc   = 1'b0;
    run_to    = 1'b0;
    case (state)
      S_IDLE: begin
        if (Req && (ProgSel != 2'd0)) begin
          accept    = 1'b1;
          state_nxt = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        // Ack is deliberately ignored here: it may still be high from the previous program.
        if (wcnt == W_LAST) begin
          state_nxt = S_RUN;
        end else begin
          w_inc = 1'b1;
        end
      end
      S_RUN: begin
        // Ack wins over the limit check; the limit check precedes the increment, so no wrap.
        if (Ack) begin
          state_nxt = S_DONE;
        end else if (CycleCount == TO_LIM) begin
          run_to    = 1'b1;
          state_nxt = S_DONE;
        end else begin
          run_inc = 1'b1;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Registered outputs, decoded from the next state so they line up with the state register.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      Start      <= 1'b0;
      Busy       <= 1'b0;
      Done       <= 1'b0;
      Timeout    <= 1'b0;
      StartAddr  <= '0;
      CycleCount <= '0;
      LastProg   <= 2'd0;
      wcnt       <= 4'd0;
    end else begin
      Start <= (state_nxt == S_LAUNCH);
      Busy  <= (state_nxt == S_LAUNCH) || (state_nxt == S_RUN);
      Done  <= (state_nxt == S_DONE);
      if (accept) begin
        LastProg   <= ProgSel;
        StartAddr  <= sel_addr;
        CycleCount <= '0;
        Timeout    <= 1'b0;
        wcnt       <= 4'd0;
      end
      if (w_inc) begin
        wcnt <= wcnt + 4'd1;
      end
      if (run_inc) begin
        CycleCount <= CycleCount + CNT_W'(1);
      end
      if (run_to) begin
        Timeout <= 1'b1;
      end
    end
  end

endmodule
